// File: rtl/ifu_pkg.sv
// Shared definitions for the IF fetch unit: FSM state encoding, NOP encoding,
// PC increment and the default boot address.
package ifu_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads a combinational instruction
// memory and fills a registered IF/ID slot. Optional: IFU_MISALIGN_EXC_EN.
module if_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             id_ready_i,
    output logic             rom_ce,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [WIDTH-1:0] if_inst_o,
`ifdef IFU_MISALIGN_EXC_EN
    output logic             if_misalign_o,
`endif
    output logic [31:0]      fetch_cnt_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] outPc_q, outPc_d;
    logic [WIDTH-1:0] outInst_q, outInst_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             load;
    logic             loadLocked;

`ifdef IFU_MISALIGN_EXC_EN
    logic misalign_q, misalign_d;
    logic lock_q, lock_d;

    assign loadLocked    = lock_q;
    assign if_misalign_o = misalign_q;
`else
    logic unusedPcBits;

    assign loadLocked   = 1'b0;
    assign unusedPcBits = ^redirect_pc_i[1:0];
`endif

    assign rom_ce      = (state_q == ST_RUN);
    assign rom_addr    = pc_q;
    assign if_valid_o  = valid_q;
    assign if_pc_o     = outPc_q;
    assign if_inst_o   = outInst_q;
    assign fetch_cnt_o = cnt_q;

    assign load = rom_ce && (!valid_q || id_ready_i) && !halt_i
                  && !redirect_valid_i && !loadLocked;

    always_comb begin
        // Every state (BOOT included) moves to HALT while halt_i is high, else RUN.
        state_d   = halt_i ? ST_HALT : ST_RUN;
        pc_d      = pc_q;
        valid_d   = valid_q;
        outPc_d   = outPc_q;
        outInst_d = outInst_q;
        cnt_d     = cnt_q;
`ifdef IFU_MISALIGN_EXC_EN
        misalign_d = misalign_q;
        lock_d     = lock_q;
`endif
        if (redirect_valid_i) begin
`ifdef IFU_MISALIGN_EXC_EN
            pc_d = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                // Present a NOP tagged misaligned and park until the next redirect.
                valid_d    = 1'b1;
                outPc_d    = redirect_pc_i;
                outInst_d  = WIDTH'(NOP_INST);
                misalign_d = 1'b1;
                lock_d     = 1'b1;
            end else begin
                valid_d    = 1'b0;
                misalign_d = 1'b0;
                lock_d     = 1'b0;
            end
`else
            pc_d    = {redirect_pc_i[WIDTH-1:2], 2'b00};
            valid_d = 1'b0;
`endif
        end else if (load) begin
            valid_d   = 1'b1;
            outPc_d   = pc_q;
            outInst_d = rom_data;
            pc_d      = pc_q + WIDTH'(PC_STEP);
            cnt_d     = cnt_q + 32'd1;
`ifdef IFU_MISALIGN_EXC_EN
            misalign_d = 1'b0;
`endif
        end else if (id_ready_i) begin
            valid_d = 1'b0;
`ifdef IFU_MISALIGN_EXC_EN
            misalign_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            outPc_q   <= '0;
            outInst_q <= '0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            outPc_q   <= outPc_d;
            outInst_q <= outInst_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef IFU_MISALIGN_EXC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            lock_q     <= lock_d;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the rv32imzicsr pipeline.
- Owns the PC and drives the instruction memory's chip-enable and byte-address inputs.
- Instruction memory is a combinational read: data is valid in the same cycle as the address.
- Captures instruction and PC into a registered IF/ID output with a valid/ready handshake. Handles branch/trap redirects, a halt request and a wrapping fetch counter.

Parameters:
- WIDTH, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- halt_i  in  1  stop fetching (debug / wfi)
- redirect_valid_i  in  1  branch/jump/trap redirect strobe
- redirect_pc_i  in  WIDTH  redirect target
- id_ready_i  in  1  decode stage can accept
- rom_ce  out  1  instruction-memory enable
- rom_addr  out  WIDTH  instruction-memory byte address (word = addr[..:2])
- rom_data  in  WIDTH  instruction-memory read data, same cycle
- if_valid_o  out  1  IF/ID entry valid
- if_pc_o  out  WIDTH  PC of presented instruction
- if_inst_o  out  WIDTH  presented instruction
- fetch_cnt_o  out  32  count of instructions loaded into IF/ID

Behaviour:
- Reset (async, rst=1):
  - pc_q=RESET_PC, state=BOOT, fetch_cnt_o=0.
  - if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - rom_ce=0.
- Address and enable: rom_addr=pc_q (combinational); rom_ce=1 only in RUN.
- BOOT: one cycle after rst deasserts; no fetch; next state RUN (or HALT if halt_i=1).
- RUN:
  - load = !if_valid_o || id_ready_i, and not halt_i, and not redirect_valid_i.
  - On load: if_valid_o<=1, if_pc_o<=pc_q, if_inst_o<=rom_data, pc_q<=pc_q+4, fetch_cnt_o++.
  - Otherwise hold pc_q and the output registers; the memory is re-read at the same address.
  - If id_ready_i=1 and no load occurs, if_valid_o<=0.
- halt_i=1 in RUN: next state HALT. The current valid entry is still drained via id_ready_i.
- HALT: rom_ce=0, no loads; halt_i=0 returns to RUN next cycle.
- Redirect (any state):
  - pc_q<=redirect_pc_i; if_valid_o<=0 (squash); no load or count that cycle.
  - Priority: redirect > halt > load. Redirect and halt together: pc updated, state HALT.
- Latency: PC to if_valid_o is 1 cycle. After a redirect, the first target instruction is valid 2 cycles after the strobe.
- Throughput: 1 instruction/cycle while id_ready_i=1.
- Wrap-around:
  - pc_q wraps 32'hFFFF_FFFC -> 0.
  - fetch_cnt_o wraps 2^32-1 -> 0.
  - No range check against memory depth; upper address bits alias.
- Reset mid-operation: immediate return to reset values; any in-flight entry is dropped.

Optional Feature:
- Macro: IFU_MISALIGN_EXC_EN.
- Defined:
  - Adds output if_misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 loads pc_q with the raw target.
  - Next cycle presents if_valid_o=1, if_pc_o=target, if_inst_o=32'h0000_0013 (NOP), if_misalign_o=1. No count.
  - Further loads are suppressed until the next redirect.
- Undefined: port absent; pc_q<={redirect_pc_i[31:2],2'b00} on every redirect.

Decomposition:
- Package ifu_pkg:
  - fetch state encoding BOOT/RUN/HALT
  - NOP_INST=32'h0000_0013
  - PC_STEP=4
  - default RESET_PC
- Single module; no natural sub-module (PC increment and output register are trivial).

Test Plan:
- Reset release, id_ready_i=1, memory word k = 0x1000+k -> BOOT cycle with rom_ce=0; then if_pc_o 0,4,8... with if_inst_o 0x1000,0x1001,...; fetch_cnt_o=3 after 3 loads.
- Backpressure: id_ready_i=0 for 3 cycles mid-stream -> if_pc_o/if_inst_o held, pc_q held, count unchanged; resumes with no loss or duplicate.
- Redirect to 0x40 while the entry for 0x08 is valid -> next cycle if_valid_o=0; following cycle if_pc_o=0x40, inst=word 16.
- halt_i=1 for 4 cycles with id_ready_i=1 -> current entry drained, rom_ce=0, no loads; release -> fetch resumes at the held PC.
- Redirect and halt in the same cycle to 0x80 -> state HALT; on release, first fetch at 0x80. Async rst pulse mid-stream -> outputs zero immediately, restart at RESET_PC.
- IFU_MISALIGN_EXC_EN: redirect to 0x42 -> if_misalign_o=1, if_pc_o=0x42, if_inst_o=0x13, no further loads until redirect to 0x44 resumes. Without the macro: fetch at 0x40.
